pixel_fetch_sched: RTL and testbench

Scheduler for the shared external pixel-memory port (addr/bank/pix_sel out, 4-bit pixel nibble in). It sequences one line-prefetch burst per scanline into a ping-pong line buffer and interleaves single-nibble host reads on the same port. Video has priority; a host request that has waited past a bound steals one issue slot. It sits between the video timing generator and the external memory pins, in the `clk_video` domain.

---
 rtl/pixel_fetch_sched.sv | 241 ++++++++++++++++++++++++
 tb/tb_pixel_fetch_sched.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch_sched.sv
// pixel_fetch_sched: arbitrates the external pixel-memory port between
// per-scanline prefetch bursts (into a ping-pong line buffer) and single
// nibble host reads. Video has priority; a host request that waits too long
// during a burst steals one issue slot. Returns are routed through a tag pipe
// that matches the memory read latency.
module pixel_fetch_sched #(
    parameter int RD_LAT    = 2,
    parameter int FETCH_LEN = 64,
    parameter int MAX_WAIT  = 8,
    localparam int KW       = $clog2(FETCH_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          line_start,
    input  logic [8:0]    line_addr,
    input  logic          line_bank,
    output logic [8:0]    mem_addr,
    output logic          mem_bank,
    output logic [2:0]    mem_sel,
    input  logic [3:0]    mem_pixel,
    output logic          lb_we,
    output logic [KW-1:0] lb_waddr,
    output logic [3:0]    lb_wdata,
    output logic          lb_half,
    input  logic          host_req,
    input  logic [8:0]    host_addr,
    input  logic          host_bank,
    input  logic [2:0]    host_sel,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [3:0]    host_rdata,
    output logic          fetch_done,
    output logic          overrun
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [KW-1:0] K_LAST    = KW'(FETCH_LEN - 1);
    localparam logic [3:0]    WAIT_LIM  = 4'(MAX_WAIT);
    localparam logic [3:0]    WAIT_SAT  = 4'd15;

    state_t        state_reg, state_next;
    logic [KW-1:0] k_reg, k_next;
    logic [8:0]    base_reg, base_next;
    logic          bank_reg, bank_next;
    logic [3:0]    wait_cnt_reg, wait_cnt_next;
    logic          half_reg, half_next;
    logic          overrun_reg, overrun_next;

    logic          issue_video, issue_host;
    logic [8:0]    iss_addr;
    logic          iss_bank;
    logic [2:0]    iss_sel;
    logic [8:0]    k_word;

    logic [8:0]    mem_addr_reg;
    logic          mem_bank_reg;
    logic [2:0]    mem_sel_reg;
    logic          host_gnt_reg;
    logic          lb_we_reg;
    logic [KW-1:0] lb_waddr_reg;
    logic [3:0]    lb_wdata_reg;
    logic          host_rvalid_reg;
    logic [3:0]    host_rdata_reg;
    logic          fetch_done_reg;

    // Tag pipe: one entry per issue, stage RD_LAT-1 lines up with mem_pixel.
    logic [RD_LAT-1:0]         tag_valid_reg, tag_valid_next;
    logic [RD_LAT-1:0]         tag_host_reg, tag_host_next;
    logic [RD_LAT-1:0][KW-1:0] tag_k_reg, tag_k_next;

    logic          tap_valid, tap_host;
    logic [KW-1:0] tap_k;

    // Word offset of nibble k: eight nibbles per word, 9-bit address wrap.
    assign k_word = 9'(k_reg >> 3);

    // Next-state, issue selection and wait-counter update.
    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        base_next     = base_reg;
        bank_next     = bank_reg;
        wait_cnt_next = wait_cnt_reg;
        half_next     = half_reg;
        overrun_next  = overrun_reg;
        issue_video   = 1'b0;
        issue_host    = 1'b0;
        iss_addr      = mem_addr_reg;
        iss_bank      = mem_bank_reg;
        iss_sel       = mem_sel_reg;

        case (state_reg)
            IDLE: begin
                if (line_start) begin
                    base_next  = line_addr;
                    bank_next  = line_bank;
                    k_next     = '0;
                    half_next  = ~half_reg;
                    state_next = BURST;
                end else if (host_req) begin
                    issue_host = 1'b1;
                end
            end
            BURST: begin
                if (line_start) begin
                    // Abandon the running burst; in-flight tags still drain.
                    overrun_next = 1'b1;
                    base_next    = line_addr;
                    bank_next    = line_bank;
                    k_next       = '0;
                    half_next    = ~half_reg;
                end else if (host_req && (wait_cnt_reg >= WAIT_LIM)) begin
                    issue_host = 1'b1;
                end else begin
                    issue_video = 1'b1;
                    k_next      = k_reg + 1'b1;
                    if (k_reg == K_LAST) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (issue_host) begin
            iss_addr = host_addr;
            iss_bank = host_bank;
            iss_sel  = host_sel;
        end else if (issue_video) begin
            iss_addr = base_reg + k_word;
            iss_bank = bank_reg;
            iss_sel  = k_reg[2:0];
        end

        if (issue_host) begin
            wait_cnt_next = '0;
        end else if ((state_reg == BURST) && host_req && (wait_cnt_reg != WAIT_SAT)) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    // Tag pipe shift: head takes the current issue, each stage copies the previous.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_next[gi] = issue_video | issue_host;
                assign tag_host_next[gi]  = issue_host;
                assign tag_k_next[gi]     = k_reg;
            end else begin : g_body
                assign tag_valid_next[gi] = tag_valid_reg[gi-1];
                assign tag_host_next[gi]  = tag_host_reg[gi-1];
                assign tag_k_next[gi]     = tag_k_reg[gi-1];
            end
        end
    endgenerate

    assign tap_valid = tag_valid_reg[RD_LAT-1];
    assign tap_host  = tag_host_reg[RD_LAT-1];
    assign tap_k     = tag_k_reg[RD_LAT-1];

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            base_reg      <= '0;
            bank_reg      <= 1'b0;
            wait_cnt_reg  <= '0;
            half_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            tag_valid_reg <= '0;
            tag_host_reg  <= '0;
            tag_k_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            base_reg      <= base_next;
            bank_reg      <= bank_next;
            wait_cnt_reg  <= wait_cnt_next;
            half_reg      <= half_next;
            overrun_reg   <= overrun_next;
            tag_valid_reg <= tag_valid_next;
            tag_host_reg  <= tag_host_next;
            tag_k_reg     <= tag_k_next;
        end
    end

    // Registered port request, grant and return routing.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_reg    <= '0;
            mem_bank_reg    <= 1'b0;
            mem_sel_reg     <= '0;
            host_gnt_reg    <= 1'b0;
            lb_we_reg       <= 1'b0;
            lb_waddr_reg    <= '0;
            lb_wdata_reg    <= '0;
            host_rvalid_reg <= 1'b0;
            host_rdata_reg  <= '0;
            fetch_done_reg  <= 1'b0;
        end else begin
            if (issue_video || issue_host) begin
                mem_addr_reg <= iss_addr;
                mem_bank_reg <= iss_bank;
                mem_sel_reg  <= iss_sel;
            end
            host_gnt_reg <= issue_host;

            lb_we_reg <= tap_valid & ~tap_host;
            if (tap_valid && !tap_host) begin
                lb_waddr_reg <= tap_k;
                lb_wdata_reg <= mem_pixel;
            end

            host_rvalid_reg <= tap_valid & tap_host;
            if (tap_valid && tap_host) begin
                host_rdata_reg <= mem_pixel;
            end

            // An abandoned burst never issues its last nibble, so only
            // completed bursts reach this.
            fetch_done_reg <= lb_we_reg && (lb_waddr_reg == K_LAST);
        end
    end

    assign mem_addr    = mem_addr_reg;
    assign mem_bank    = mem_bank_reg;
    assign mem_sel     = mem_sel_reg;
    assign host_gnt    = host_gnt_reg;
    assign lb_we       = lb_we_reg;
    assign lb_waddr    = lb_waddr_reg;
    assign lb_wdata    = lb_wdata_reg;
    assign lb_half     = half_reg;
    assign host_rvalid = host_rvalid_reg;
    assign host_rdata  = host_rdata_reg;
    assign fetch_done  = fetch_done_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_pixel_fetch_sched.sv
// Directed bench for pixel_fetch_sched: line bursts, address wrap, host
// reads in idle, slot stealing, overrun restart and reset mid-burst.
module tb_pixel_fetch_sched;

    localparam int RD_LAT    = 2;
    localparam int FETCH_LEN = 64;
    localparam int MAX_WAIT  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       line_start;
    logic [8:0] line_addr;
    logic       line_bank;
    logic [8:0] mem_addr;
    logic       mem_bank;
    logic [2:0] mem_sel;
    logic [3:0] mem_pixel;
    logic       lb_we;
    logic [5:0] lb_waddr;
    logic [3:0] lb_wdata;
    logic       lb_half;
    logic       host_req;
    logic [8:0] host_addr;
    logic       host_bank;
    logic [2:0] host_sel;
    logic       host_gnt;
    logic       host_rvalid;
    logic [3:0] host_rdata;
    logic       fetch_done;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    pixel_fetch_sched #(.RD_LAT(RD_LAT), .FETCH_LEN(FETCH_LEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .line_start(line_start), .line_addr(line_addr), .line_bank(line_bank),
        .mem_addr(mem_addr), .mem_bank(mem_bank), .mem_sel(mem_sel), .mem_pixel(mem_pixel),
        .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_half(lb_half),
        .host_req(host_req), .host_addr(host_addr), .host_bank(host_bank), .host_sel(host_sel),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .fetch_done(fetch_done), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: nibble is a fixed function of the issued {bank, addr, sel}.
    function automatic logic [3:0] mem_f(input logic [8:0] a, input logic [2:0] s, input logic b);
        return a[3:0] ^ {1'b0, s} ^ {b, 3'b000} ^ 4'hA;
    endfunction

    // One register stage plus the DUT's registered port gives RD_LAT=2.
    logic [12:0] mem_pipe = '0;
    always @(posedge clk) mem_pipe <= {mem_bank, mem_addr, mem_sel};
    assign mem_pixel = mem_f(mem_pipe[11:3], mem_pipe[2:0], mem_pipe[12]);

    // Observation logs, sampled on the falling edge.
    logic [12:0] port_log [int];
    int          wr_cyc[$];
    logic [5:0]  wr_addr[$];
    logic [3:0]  wr_data[$];
    int          done_q[$];
    int          rv_cyc[$];
    logic [3:0]  rv_data[$];
    int          gnt_q[$];

    always @(negedge clk) begin
        port_log[cyc] = {mem_bank, mem_addr, mem_sel};
        if (lb_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(lb_waddr);
            wr_data.push_back(lb_wdata);
        end
        if (fetch_done)  done_q.push_back(cyc);
        if (host_rvalid) begin
            rv_cyc.push_back(cyc);
            rv_data.push_back(host_rdata);
        end
        if (host_gnt) gnt_q.push_back(cyc);
    end

    task automatic clear_logs();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        done_q.delete(); rv_cyc.delete(); rv_data.delete(); gnt_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({mem_addr, mem_bank, mem_sel} !== 13'h0) begin
            n_bad++; $display("FAIL reset_port: got %h want 0", {mem_addr, mem_bank, mem_sel});
        end
        n_cmp++;
        if ({lb_we, lb_waddr, lb_wdata, lb_half} !== 12'h0) begin
            n_bad++; $display("FAIL reset_lb: got %h want 0", {lb_we, lb_waddr, lb_wdata, lb_half});
        end
        n_cmp++;
        if ({host_gnt, host_rvalid, host_rdata, fetch_done, overrun} !== 8'h0) begin
            n_bad++; $display("FAIL reset_ctl: got %h want 0", {host_gnt, host_rvalid, host_rdata, fetch_done, overrun});
        end
        reset = 1'b0;
        tick();
        $display("reset: outputs checked after reset");
    endtask

    task automatic test_idle_burst();
        int t;
        logic [8:0] ea;
        clear_logs();
        line_start = 1'b1; line_addr = 9'h1F0; line_bank = 1'b0;
        tick();
        t = cyc;
        line_start = 1'b0;
        wait_done(200);
        for (int i = 0; i < FETCH_LEN; i++) begin
            ea = 9'h1F0 + 9'(i / 8);
            n_cmp++;
            if (port_log[t + 1 + i] !== {1'b0, ea, 3'(i % 8)}) begin
                n_bad++; $display("FAIL burst_issue[%0d]: got %h want %h", i, port_log[t + 1 + i], {1'b0, ea, 3'(i % 8)});
            end
        end
        n_cmp++;
        if (port_log[t + 66] !== {1'b0, 9'h1F7, 3'd7}) begin
            n_bad++; $display("FAIL burst_port_hold: got %h want %h", port_log[t + 66], {1'b0, 9'h1F7, 3'd7});
        end
        n_cmp++;
        if (wr_cyc.size() !== FETCH_LEN) begin
            n_bad++; $display("FAIL burst_wr_count: got %0d want %0d", wr_cyc.size(), FETCH_LEN);
        end
        for (int i = 0; i < wr_cyc.size() && i < FETCH_LEN; i++) begin
            ea = 9'h1F0 + 9'(i / 8);
            n_cmp++;
            if ({wr_cyc[i], wr_addr[i], wr_data[i]} !== {t + 3 + i, 6'(i), mem_f(ea, 3'(i % 8), 1'b0)}) begin
                n_bad++; $display("FAIL burst_wr[%0d]: got cyc %0d a %0d d %h want cyc %0d a %0d d %h",
                    i, wr_cyc[i], wr_addr[i], wr_data[i], t + 3 + i, i, mem_f(ea, 3'(i % 8), 1'b0));
            end
        end
        n_cmp++;
        if (done_q.size() !== 1 || done_q[0] !== t + 67) begin
            n_bad++; $display("FAIL burst_done: got n=%0d first=%0d want n=1 at %0d", done_q.size(),
                done_q.size() > 0 ? done_q[0] : -1, t + 67);
        end
        n_cmp++;
        if (lb_half !== 1'b1) begin
            n_bad++; $display("FAIL burst_half: got %b want 1", lb_half);
        end
        $display("idle_burst: start %0d, %0d writes", t, wr_cyc.size());
    endtask

    task automatic test_addr_wrap();
        int t;
        logic [8:0] ea;
        clear_logs();
        line_start = 1'b1; line_addr = 9'h1FE; line_bank = 1'b1;
        tick();
        t = cyc;
        line_start = 1'b0;
        wait_done(200);
        for (int i = 0; i < FETCH_LEN; i++) begin
            ea = 9'h1FE + 9'(i / 8);
            n_cmp++;
            if (port_log[t + 1 + i] !== {1'b1, ea, 3'(i % 8)}) begin
                n_bad++; $display("FAIL wrap_issue[%0d]: got %h want %h", i, port_log[t + 1 + i], {1'b1, ea, 3'(i % 8)});
            end
        end
        n_cmp++;
        if (port_log[t + 17] !== {1'b1, 9'h000, 3'd0}) begin
            n_bad++; $display("FAIL wrap_zero: got %h want %h", port_log[t + 17], {1'b1, 9'h000, 3'd0});
        end
        n_cmp++;
        if (wr_cyc.size() !== FETCH_LEN) begin
            n_bad++; $display("FAIL wrap_wr_count: got %0d want %0d", wr_cyc.size(), FETCH_LEN);
        end
        n_cmp++;
        if (wr_cyc.size() > 63 && wr_data[63] !== mem_f(9'h005, 3'd7, 1'b1)) begin
            n_bad++; $display("FAIL wrap_last_data: got %h want %h", wr_data[63], mem_f(9'h005, 3'd7, 1'b1));
        end
        n_cmp++;
        if (lb_half !== 1'b0) begin
            n_bad++; $display("FAIL wrap_half: got %b want 0", lb_half);
        end
        $display("addr_wrap: start %0d, %0d writes", t, wr_cyc.size());
    endtask

    task automatic test_host_idle();
        int g;
        clear_logs();
        host_req = 1'b1; host_addr = 9'h0A5; host_sel = 3'd3; host_bank = 1'b0;
        tick();
        g = cyc;
        n_cmp++;
        if (host_gnt !== 1'b1) begin
            n_bad++; $display("FAIL host_gnt: got %b want 1", host_gnt);
        end
        host_req = 1'b0;
        n_cmp++;
        if ({mem_bank, mem_addr, mem_sel} !== {1'b0, 9'h0A5, 3'd3}) begin
            n_bad++; $display("FAIL host_port: got %h want %h", {mem_bank, mem_addr, mem_sel}, {1'b0, 9'h0A5, 3'd3});
        end
        repeat (4) tick();
        n_cmp++;
        if (gnt_q.size() !== 1) begin
            n_bad++; $display("FAIL host_gnt_count: got %0d want 1", gnt_q.size());
        end
        n_cmp++;
        if (rv_cyc.size() !== 1 || rv_cyc[0] !== g + 2 || rv_data[0] !== 4'hC) begin
            n_bad++; $display("FAIL host_return: got n=%0d cyc=%0d d=%h want n=1 cyc=%0d d=c", rv_cyc.size(),
                rv_cyc.size() > 0 ? rv_cyc[0] : -1, rv_data.size() > 0 ? rv_data[0] : 4'h0, g + 2);
        end
        n_cmp++;
        if (wr_cyc.size() !== 0) begin
            n_bad++; $display("FAIL host_no_lb: got %0d writes want 0", wr_cyc.size());
        end
        $display("host_idle: gnt %0d, rdata %h", g, host_rdata);
    endtask

    task automatic test_steal();
        int t;
        int k;
        int n;
        logic [8:0] ea;
        clear_logs();
        line_start = 1'b1; line_addr = 9'h040; line_bank = 1'b1;
        host_req = 1'b1; host_addr = 9'h033; host_sel = 3'd5; host_bank = 1'b1;
        tick();
        t = cyc;
        line_start = 1'b0;
        n = 0;
        while (done_q.size() == 0 && n < 200) begin
            if (host_gnt) host_req = 1'b0;
            tick();
            n++;
        end
        host_req = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (gnt_q.size() !== 1 || gnt_q[0] !== t + 9) begin
            n_bad++; $display("FAIL steal_gnt: got n=%0d cyc=%0d want cyc %0d", gnt_q.size(),
                gnt_q.size() > 0 ? gnt_q[0] : -1, t + 9);
        end
        n_cmp++;
        if (port_log[t + 9] !== {1'b1, 9'h033, 3'd5}) begin
            n_bad++; $display("FAIL steal_port: got %h want %h", port_log[t + 9], {1'b1, 9'h033, 3'd5});
        end
        n_cmp++;
        if (port_log[t + 10] !== {1'b1, 9'h041, 3'd0}) begin
            n_bad++; $display("FAIL steal_resume: got %h want %h", port_log[t + 10], {1'b1, 9'h041, 3'd0});
        end
        n_cmp++;
        if (port_log[t + 65] !== {1'b1, 9'h047, 3'd7}) begin
            n_bad++; $display("FAIL steal_last_issue: got %h want %h", port_log[t + 65], {1'b1, 9'h047, 3'd7});
        end
        n_cmp++;
        if (rv_cyc.size() !== 1 || rv_cyc[0] !== t + 11 || rv_data[0] !== mem_f(9'h033, 3'd5, 1'b1)) begin
            n_bad++; $display("FAIL steal_return: got n=%0d cyc=%0d want cyc %0d d %h", rv_cyc.size(),
                rv_cyc.size() > 0 ? rv_cyc[0] : -1, t + 11, mem_f(9'h033, 3'd5, 1'b1));
        end
        n_cmp++;
        if (wr_cyc.size() !== FETCH_LEN) begin
            n_bad++; $display("FAIL steal_wr_count: got %0d want %0d", wr_cyc.size(), FETCH_LEN);
        end
        for (int i = 0; i < wr_cyc.size() && i < FETCH_LEN; i++) begin
            k = (i < 8) ? t + 3 + i : t + 4 + i;
            ea = 9'h040 + 9'(i / 8);
            n_cmp++;
            if ({wr_cyc[i], wr_addr[i], wr_data[i]} !== {k, 6'(i), mem_f(ea, 3'(i % 8), 1'b1)}) begin
                n_bad++; $display("FAIL steal_wr[%0d]: got cyc %0d a %0d d %h want cyc %0d a %0d", i,
                    wr_cyc[i], wr_addr[i], wr_data[i], k, i);
            end
        end
        n_cmp++;
        if (done_q.size() !== 1 || done_q[0] !== t + 68) begin
            n_bad++; $display("FAIL steal_done: got n=%0d want at %0d", done_q.size(), t + 68);
        end
        $display("steal: start %0d, host gnt %0d", t, gnt_q.size() > 0 ? gnt_q[0] : -1);
    endtask

    task automatic test_overrun();
        int t0;
        int t1;
        int j;
        logic [8:0] ea;
        clear_logs();
        line_start = 1'b1; line_addr = 9'h100; line_bank = 1'b0;
        tick();
        t0 = cyc;
        line_start = 1'b0;
        repeat (19) tick();
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++; $display("FAIL overrun_pre: got %b want 0", overrun);
        end
        line_start = 1'b1; line_addr = 9'h180; line_bank = 1'b0;
        tick();
        t1 = cyc;
        line_start = 1'b0;
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++; $display("FAIL overrun_set: got %b want 1", overrun);
        end
        wait_done(200);
        n_cmp++;
        if (wr_cyc.size() !== 19 + FETCH_LEN) begin
            n_bad++; $display("FAIL overrun_wr_count: got %0d want %0d", wr_cyc.size(), 19 + FETCH_LEN);
        end
        for (int i = 0; i < wr_cyc.size() && i < 19 + FETCH_LEN; i++) begin
            if (i < 19) begin
                j = i;
                ea = 9'h100 + 9'(j / 8);
                k_check: begin
                    n_cmp++;
                    if ({wr_cyc[i], wr_addr[i], wr_data[i]} !== {t0 + 3 + j, 6'(j), mem_f(ea, 3'(j % 8), 1'b0)}) begin
                        n_bad++; $display("FAIL overrun_old_wr[%0d]: got cyc %0d a %0d want cyc %0d a %0d",
                            i, wr_cyc[i], wr_addr[i], t0 + 3 + j, j);
                    end
                end
            end else begin
                j = i - 19;
                ea = 9'h180 + 9'(j / 8);
                n_cmp++;
                if ({wr_cyc[i], wr_addr[i], wr_data[i]} !== {t1 + 3 + j, 6'(j), mem_f(ea, 3'(j % 8), 1'b0)}) begin
                    n_bad++; $display("FAIL overrun_new_wr[%0d]: got cyc %0d a %0d want cyc %0d a %0d",
                        i, wr_cyc[i], wr_addr[i], t1 + 3 + j, j);
                end
            end
        end
        n_cmp++;
        if (done_q.size() !== 1 || done_q[0] !== t1 + 67) begin
            n_bad++; $display("FAIL overrun_done: got n=%0d want one at %0d", done_q.size(), t1 + 67);
        end
        n_cmp++;
        if ({overrun, lb_half} !== 2'b11) begin
            n_bad++; $display("FAIL overrun_sticky_half: got %b want 11", {overrun, lb_half});
        end
        $display("overrun: first %0d, restart %0d, %0d writes", t0, t1, wr_cyc.size());
    endtask

    task automatic test_simultaneous_reset();
        int t;
        int g;
        int n;
        clear_logs();
        line_start = 1'b1; line_addr = 9'h0C0; line_bank = 1'b0;
        host_req = 1'b1; host_addr = 9'h0F0; host_sel = 3'd1; host_bank = 1'b1;
        tick();
        t = cyc;
        line_start = 1'b0;
        n_cmp++;
        if (host_gnt !== 1'b0) begin
            n_bad++; $display("FAIL simul_no_gnt: got %b want 0", host_gnt);
        end
        n = 0;
        while (!host_gnt && n < 20) begin
            tick();
            n++;
        end
        g = cyc;
        host_req = 1'b0;
        n_cmp++;
        if (host_gnt !== 1'b1 || (g - t) > MAX_WAIT + 1) begin
            n_bad++; $display("FAIL simul_gnt_bound: got gnt=%b after %0d want gnt within %0d", host_gnt, g - t, MAX_WAIT + 1);
        end
        n_cmp++;
        if (port_log[t + 1] !== {1'b0, 9'h0C0, 3'd0}) begin
            n_bad++; $display("FAIL simul_video_first: got %h want %h", port_log[t + 1], {1'b0, 9'h0C0, 3'd0});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({mem_addr, mem_bank, mem_sel, lb_we, lb_waddr, lb_wdata, lb_half} !== 25'h0) begin
            n_bad++; $display("FAIL midreset_port_lb: got %h want 0", {mem_addr, mem_bank, mem_sel, lb_we, lb_waddr, lb_wdata, lb_half});
        end
        n_cmp++;
        if ({host_gnt, host_rvalid, host_rdata, fetch_done, overrun} !== 8'h0) begin
            n_bad++; $display("FAIL midreset_ctl: got %h want 0", {host_gnt, host_rvalid, host_rdata, fetch_done, overrun});
        end
        clear_logs();
        repeat (6) tick();
        n_cmp++;
        if (wr_cyc.size() + rv_cyc.size() + done_q.size() + gnt_q.size() !== 0) begin
            n_bad++; $display("FAIL midreset_drain: got wr %0d rv %0d done %0d gnt %0d want all 0",
                wr_cyc.size(), rv_cyc.size(), done_q.size(), gnt_q.size());
        end
        $display("simultaneous: line %0d, host gnt %0d, reset applied", t, g);
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; line_addr = '0; line_bank = 1'b0;
        host_req = 1'b0; host_addr = '0; host_bank = 1'b0; host_sel = '0;
        repeat (3) tick();
        test_reset();
        test_idle_burst();
        test_addr_wrap();
        test_host_idle();
        test_steal();
        test_overrun();
        test_simultaneous_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
